// File: rtl/y_pc_stage_pkg.sv
// Shared constants for the PC stage: FSM state encodings and next-PC select codes.
package y_pc_stage_pkg;

    localparam int unsigned PC_SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } pc_state_e;

    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JALR   = 2'b11;

endpackage

// File: rtl/yMux4to1.sv
// Four-input, SIZE-bit wide combinational selector used for next-PC source choice.
module yMux4to1
    import y_pc_stage_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic [SIZE-1:0]     in0_i,
    input  logic [SIZE-1:0]     in1_i,
    input  logic [SIZE-1:0]     in2_i,
    input  logic [SIZE-1:0]     in3_i,
    input  logic [PC_SEL_W-1:0] sel_i,
    output logic [SIZE-1:0]     out_c_o
);

    always_comb begin
        out_c_o = in0_i;
        case (sel_i)
            PC_SEL_SEQ:    out_c_o = in0_i;
            PC_SEL_BRANCH: out_c_o = in1_i;
            PC_SEL_JUMP:   out_c_o = in2_i;
            PC_SEL_JALR:   out_c_o = in3_i;
        endcase
    end

endmodule

// File: rtl/y_pc_stage.sv
// Fetch PC stage: holds the fetch address, offers it downstream with valid/ready,
// advances on accepted transfers and traps misaligned targets in a sticky FAULT state.
module y_pc_stage
    import y_pc_stage_pkg::*;
#(
    parameter int unsigned    SIZE         = 32,
    parameter logic [SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic [SIZE-1:0]     imm,
    input  logic [SIZE-1:0]     jump_target,
    input  logic [SIZE-1:0]     alu_result,
    input  logic                out_ready,
    output logic [SIZE-1:0]     pc,
    output logic [SIZE-1:0]     pc_plus4,
    output logic                out_valid,
    output logic                fault,
    output logic [SIZE-1:0]     fault_pc,
    output logic [SIZE-1:0]     fetch_count
);

    pc_state_e       state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic [SIZE-1:0] fault_pc_q, fault_pc_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] pc_plus4_q;
    logic            out_valid_q;
    logic            fault_q;

    logic [SIZE-1:0] seq_pc;
    logic [SIZE-1:0] br_pc;
    logic [SIZE-1:0] jalr_pc;
    logic [SIZE-1:0] cand;

    // Candidate sources; all arithmetic wraps modulo 2^SIZE.
    assign seq_pc  = pc_q + SIZE'(4);
    assign br_pc   = pc_q + imm;
    assign jalr_pc = alu_result & ~SIZE'(1);

    yMux4to1 #(
        .SIZE (SIZE)
    ) u_next_pc_mux (
        .in0_i   (seq_pc),
        .in1_i   (br_pc),
        .in2_i   (jump_target),
        .in3_i   (jalr_pc),
        .sel_i   (pc_sel),
        .out_c_o (cand)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_VECTOR;
            pc_plus4_q  <= RESET_VECTOR + SIZE'(4);
            fault_pc_q  <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_d + SIZE'(4);
            fault_pc_q  <= fault_pc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    // A transfer only happens in RUN, where valid is high, so out_ready alone qualifies it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    cnt_d = cnt_q + SIZE'(1);
                    if (cand[1:0] == 2'b00) begin
                        pc_d    = cand;
                        state_d = en ? ST_RUN : ST_IDLE;
                    end else begin
                        fault_pc_d = cand;
                        state_d    = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign out_valid   = out_valid_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = cnt_q;

endmodule
